burst_mem: RTL
==============

# burst_mem

Parametrised latency memory model with a shared tri-state data bus, multi-beat bursts, byte-strobed writes and a per-beat `ready` handshake. It is the successor to the single-word `mem` model. It serves as the backing store seen by the accelerator's memory-side controller and testbenches. Each accepted request waits `LATENCY` cycles, then streams `burst_len+1` consecutive-address beats, one per clock.

## Interface
- `DATA_WIDTH`, 32: word width in bits; must be a multiple of 8.
- `ADDRESS_WIDTH`, 8: word address width; depth = 2^ADDRESS_WIDTH words.
- `LATENCY`, 3: cycles from request acceptance to first `ready`; minimum 1.
- `BURST_WIDTH`, 4: width of `burst_len`; max burst = 2^BURST_WIDTH beats.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `sel`  in  1  request/hold; must stay high for the whole transaction.
- `w_en`  in  1  1 = write burst, 0 = read burst; sampled at acceptance only.
- `address_bus`  in  ADDRESS_WIDTH  start word address; sampled at acceptance only.
- `burst_len`  in  BURST_WIDTH  beats minus one; sampled at acceptance only.
- `w_strb`  in  DATA_WIDTH/8  per-byte write enables; sampled on every write beat.
- `data_bus`  inout  DATA_WIDTH  driven by the block only during read beats, else Z.
- `ready`  out  1  current beat valid (read data driven / write data consumed at next edge).
- `busy`  out  1  high from acceptance until the block returns to IDLE.

## Operation
- States: IDLE, WAIT, BEAT, DONE.
- IDLE:
  - `sel=1` at a rising edge accepts the request.
  - Captures `w_en`, `address_bus` into the beat address register, and `burst_len` into the beat counter.
  - Loads the latency counter; goes to WAIT.
- WAIT: counts `LATENCY` edges (including the accept edge), then enters BEAT with `ready=1`.
- BEAT:
  - Each edge with `sel=1` completes one beat.
  - Write beat: each byte i with `w_strb[i]=1` is written to `mem[addr]`; other bytes are unchanged.
  - Read beat: `data_bus = mem[addr]` for the entire cycle in which `ready=1`.
  - After each beat the address increments modulo 2^ADDRESS_WIDTH (wraps 255 -> 0 at default) and the beat counter decrements.
  - The edge completing the last beat moves to DONE with `ready=0`.
- DONE: stays while `sel=1`; `sel=0` -> IDLE. A continuously held `sel` therefore never retriggers a request.
- Abort: `sel=0` at any edge in WAIT or BEAT -> IDLE, `ready=0`, `busy=0`.
  - That edge does not commit a write beat.
  - Beats already committed stay in memory.
- `w_en`, `address_bus` and `burst_len` changes after acceptance are ignored.
- Memory contents are not reset. Reads of never-written words return X in simulation.

## Timing
- Reset (async, immediate):
  - State = IDLE; `ready=0`; `busy=0`; `data_bus`=Z; counters = 0.
  - A reset mid-burst drops the transaction; committed beats persist.
- Acceptance at edge T0:
  - `busy=1` after T0.
  - `ready` rises after edge T0+LATENCY.
  - Beat i spans edges T0+LATENCY+i .. T0+LATENCY+i+1.
  - Write beat i commits at edge T0+LATENCY+i+1.
- `ready` stays high for exactly `burst_len+1` consecutive cycles when `sel` is held.
- After the last beat: `ready` falls and `busy` stays high (DONE). `busy` falls on the edge after `sel` is seen low.
- Next acceptance is possible at the first edge with `sel=1` after returning to IDLE. Minimum one idle cycle between bursts.
- Read data is combinational from the registered beat address. It is valid the whole `ready` cycle and is safe to sample at negedge or at the closing posedge.
- The block drives `data_bus` only when state=BEAT, captured `w_en`=0 and `sel`=1. The testbench drives the bus only when `sel`=1 and `w_en`=1.

## Test plan
- Single write then read:
  - Write 0xDEADBEEF to addr 5, `burst_len=0`, `w_strb=4'hF`, LATENCY=3 -> `ready` rises exactly 3 edges after accept and lasts 1 cycle.
  - Read of addr 5 returns 0xDEADBEEF.
- Burst:
  - Write addr 16, `burst_len=3`, data 1,2,3,4 -> `ready` high 4 consecutive cycles.
  - Read addr 16, len 3 returns 1,2,3,4 in order; `busy` falls one edge after `sel` drops.
- Wrap-around: write addr 254, len 3, data A,B,C,D -> read addr 254, len 3 returns A,B,C,D, with addr 0 = C and addr 1 = D.
- Byte strobes:
  - Write 0x11223344 to addr 9 with `w_strb=4'hF`.
  - Then write 0xAABBCCDD with `w_strb=4'b0101` -> read returns 0x11BB33DD.
- Abort and reset:
  - Write burst of 4 at addr 32 with `sel` dropped after the 2nd beat -> only addr 32, 33 updated; `ready=0` next cycle.
  - Assert `rst` mid-read -> `ready`, `busy` = 0 and `data_bus`=Z immediately; next request behaves normally.
- Held `sel`: keep `sel=1` for 10 cycles after a 1-beat read -> exactly one `ready` pulse, no second transaction.

Source files
------------

// File: rtl/burst_mem.sv
// Latency memory model with a shared tri-state data bus, multi-beat bursts,
// byte-strobed writes and a per-beat ready handshake.
module burst_mem #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned LATENCY       = 3,
  parameter int unsigned BURST_WIDTH   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sel,
  input  logic                      w_en,
  input  logic [ADDRESS_WIDTH-1:0]  address_bus,
  input  logic [BURST_WIDTH-1:0]    burst_len,
  input  logic [DATA_WIDTH/8-1:0]   w_strb,
  inout  wire  [DATA_WIDTH-1:0]     data_bus,
  output logic                      ready,
  output logic                      busy
);

  localparam int unsigned NBYTES = DATA_WIDTH / 8;
  localparam int unsigned DEPTH  = 2 ** ADDRESS_WIDTH;
  localparam int unsigned LAT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    BEAT,
    DONE
  } state_e;

  state_e                    state_q, state_d;
  logic                      we_q, we_d;
  logic [ADDRESS_WIDTH-1:0]  addr_q, addr_d;
  logic [BURST_WIDTH-1:0]    cnt_q, cnt_d;
  logic [LAT_W-1:0]          lat_q, lat_d;
  logic                      beat_fire;
  logic                      rd_drive;
  logic [DATA_WIDTH-1:0]     rd_data;

  logic [DATA_WIDTH-1:0]     mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
    end
  end

  // The accept edge is the first of the LATENCY WAIT edges, so the counter
  // starts at LATENCY-1 and BEAT is entered on the edge that sees it at zero.
  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    lat_d     = lat_q;
    beat_fire = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sel) begin
          we_d    = w_en;
          addr_d  = address_bus;
          cnt_d   = burst_len;
          lat_d   = LAT_W'(LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (!sel) begin
          state_d = IDLE;
        end else if (lat_q == '0) begin
          state_d = BEAT;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      BEAT: begin
        if (!sel) begin
          state_d = IDLE;
        end else begin
          beat_fire = 1'b1;
          addr_d    = addr_q + ADDRESS_WIDTH'(1);
          cnt_d     = cnt_q - BURST_WIDTH'(1);
          if (cnt_q == '0) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (!sel) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Storage is deliberately not reset; beat_fire is already gated by the
  // asynchronously reset state, so a reset can never commit a beat.
  always_ff @(posedge clk) begin
    if (beat_fire && we_q) begin
      for (int unsigned b = 0; b < NBYTES; b++) begin
        if (w_strb[b]) begin
          mem[addr_q][8*b +: 8] <= data_bus[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    rd_data  = mem[addr_q];
    rd_drive = (state_q == BEAT) && !we_q && sel;
    ready    = (state_q == BEAT);
    busy     = (state_q != IDLE);
  end

  assign data_bus = rd_drive ? rd_data : 'z;

endmodule
